// File: rtl/except_ctrl.sv
// except_ctrl: exception/interrupt commit controller for the MEM stage.
//
// Picks the highest-priority exception of the MEM-stage instruction, or a
// pending interrupt. If a data-bus transaction is outstanding, it holds the
// pipeline until the bus drains. It then issues a single-cycle commit that
// drives the CP0 exception inputs, the pipeline flush and the redirect PC.
//
// Ports
//   clk, rst              clock, synchronous active-low reset
//   mem_valid_i           MEM-stage instruction is valid
//   pc_i                  PC of the MEM-stage instruction
//   is_in_delayslot_i     MEM-stage instruction sits in a delay slot
//   exc_flags_i[8:0]      fetch AdEL, RI, syscall, break, ov, trap,
//                         data AdEL, AdES, ERET (bit 0 .. bit 8)
//   data_addr_i           load/store effective address
//   status_i/cause_i/epc_i  forwarded CP0 values
//   bus_busy_i            data-bus transaction outstanding
//   excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o
//                         CP0 exception inputs, non-zero only in commit
//   flush_o, new_pc_o     pipeline flush and redirect PC (commit only)
//   stall_o               freeze IF..MEM while an exception is pending
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | watching the MEM stage for an exception or interrupt
// DRAIN  | exception captured, waiting for the data bus to go idle
// COMMIT | one-cycle commit pulse driven from the captured values

module except_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic [8:0]  exc_flags_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        bus_busy_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        stall_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state;

  logic        int_pend;
  logic        detect;
  logic [31:0] sel_code;
  logic [31:0] sel_bad;
  logic [31:0] sel_target;

  logic [31:0] cap_code;
  logic [31:0] cap_pc;
  logic        cap_ds;
  logic [31:0] cap_bad;
  logic [31:0] cap_target;

  assign int_pend = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));
  assign detect   = mem_valid_i & (int_pend | (|exc_flags_i));

  // Priority select. Only the winner contributes a code, a bad address and
  // a redirect target. An interrupt beats everything, including ERET.
  always_comb begin
    sel_code   = 32'h0;
    sel_bad    = 32'h0;
    sel_target = EXC_VECTOR;
    if (int_pend) begin
      sel_code = 32'h01;
    end else if (exc_flags_i[0]) begin
      sel_code = 32'h04;
      sel_bad  = pc_i;
    end else if (exc_flags_i[1]) begin
      sel_code = 32'h0a;
    end else if (exc_flags_i[2]) begin
      sel_code = 32'h08;
    end else if (exc_flags_i[3]) begin
      sel_code = 32'h09;
    end else if (exc_flags_i[4]) begin
      sel_code = 32'h0c;
    end else if (exc_flags_i[5]) begin
      sel_code = 32'h0d;
    end else if (exc_flags_i[6]) begin
      sel_code = 32'h04;
      sel_bad  = data_addr_i;
    end else if (exc_flags_i[7]) begin
      sel_code = 32'h05;
      sel_bad  = data_addr_i;
    end else if (exc_flags_i[8]) begin
      sel_code   = 32'h0e;
      sel_target = epc_i;
    end
  end

  // Stall is combinational in the detection cycle so the offending
  // instruction cannot leave MEM before it is captured.
  assign stall_o = ((state == IDLE) & detect) | (state == DRAIN);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state               <= IDLE;
      cap_code            <= 32'h0;
      cap_pc              <= 32'h0;
      cap_ds              <= 1'b0;
      cap_bad             <= 32'h0;
      cap_target          <= 32'h0;
      excepttype_o        <= 32'h0;
      current_inst_addr_o <= 32'h0;
      is_in_delayslot_o   <= 1'b0;
      bad_addr_o          <= 32'h0;
      flush_o             <= 1'b0;
      new_pc_o            <= 32'h0;
    end else begin
      // Outputs are zero unless the next cycle is the commit cycle.
      excepttype_o        <= 32'h0;
      current_inst_addr_o <= 32'h0;
      is_in_delayslot_o   <= 1'b0;
      bad_addr_o          <= 32'h0;
      flush_o             <= 1'b0;
      new_pc_o            <= 32'h0;
      case (state)
        IDLE: begin
          if (detect) begin
            cap_code   <= sel_code;
            cap_pc     <= pc_i;
            cap_ds     <= is_in_delayslot_i;
            cap_bad    <= sel_bad;
            cap_target <= sel_target;
            if (bus_busy_i) begin
              state <= DRAIN;
            end else begin
              // Bus already idle: commit straight from the live selection.
              state               <= COMMIT;
              excepttype_o        <= sel_code;
              current_inst_addr_o <= pc_i;
              is_in_delayslot_o   <= is_in_delayslot_i;
              bad_addr_o          <= sel_bad;
              flush_o             <= 1'b1;
              new_pc_o            <= sel_target;
            end
          end
        end
        DRAIN: begin
          if (!bus_busy_i) begin
            state               <= COMMIT;
            excepttype_o        <= cap_code;
            current_inst_addr_o <= cap_pc;
            is_in_delayslot_o   <= cap_ds;
            bad_addr_o          <= cap_bad;
            flush_o             <= 1'b1;
            new_pc_o            <= cap_target;
          end
        end
        COMMIT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_except_ctrl.sv
// Self-checking bench for except_ctrl: directed cases followed by random
// exceptions, all compared against a priority-rule reference model.
module tb_except_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i;
  logic [31:0] pc_i;
  logic        is_in_delayslot_i;
  logic [8:0]  exc_flags_i;
  logic [31:0] data_addr_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic        bus_busy_i;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic [31:0] bad_addr_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        stall_o;

  int checks = 0;
  int failures = 0;

  except_ctrl #(.EXC_VECTOR(VEC)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .pc_i(pc_i),
    .is_in_delayslot_i(is_in_delayslot_i), .exc_flags_i(exc_flags_i),
    .data_addr_i(data_addr_i), .status_i(status_i), .cause_i(cause_i),
    .epc_i(epc_i), .bus_busy_i(bus_busy_i),
    .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
    .is_in_delayslot_o(is_in_delayslot_o), .bad_addr_o(bad_addr_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Reference model: architectural rules, first set flag in priority order.
  function automatic void ref_model(
    input logic v, input logic [8:0] f, input logic [31:0] st, input logic [31:0] ca,
    input logic [31:0] pc, input logic [31:0] da, input logic [31:0] epc,
    output logic det, output logic [31:0] code, output logic [31:0] bad,
    output logic [31:0] tgt);
    int codes [9] = '{4, 10, 8, 9, 12, 13, 4, 5, 14};
    logic ip;
    int k;
    ip   = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'h0);
    det  = v && (ip || (f != 9'h0));
    code = 0; bad = 0; tgt = VEC;
    k = -1;
    if (ip) code = 32'h1;
    else begin
      for (int i = 0; i < 9; i++) if (f[i] && k < 0) k = i;
      if (k >= 0) begin
        code = codes[k];
        if (k == 0) bad = pc;
        if (k == 6 || k == 7) bad = da;
        if (k == 8) tgt = epc;
      end
    end
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_type"}, excepttype_o, 32'h0);
    chk({tag, "_addr"}, current_inst_addr_o, 32'h0);
    chk({tag, "_ds"}, {31'h0, is_in_delayslot_o}, 32'h0);
    chk({tag, "_bad"}, bad_addr_o, 32'h0);
    chk({tag, "_flush"}, {31'h0, flush_o}, 32'h0);
    chk({tag, "_newpc"}, new_pc_o, 32'h0);
  endtask

  task automatic scramble_inputs();
    mem_valid_i       = 1'($urandom);
    exc_flags_i       = 9'($urandom);
    pc_i              = $urandom;
    data_addr_i       = $urandom;
    status_i          = $urandom;
    cause_i           = $urandom;
    epc_i             = $urandom;
    is_in_delayslot_i = 1'($urandom);
  endtask

  // One exception episode. Starts just after a rising edge; ends at a falling
  // edge. busy_n = number of cycles bus_busy_i stays high from detection.
  task automatic do_txn(input logic v, input logic [8:0] f, input logic [31:0] pc,
                        input logic ds, input logic [31:0] da, input logic [31:0] st,
                        input logic [31:0] ca, input logic [31:0] epc, input int busy_n);
    logic det;
    logic [31:0] code, bad, tgt;
    @(posedge clk); #1;
    mem_valid_i = v; exc_flags_i = f; pc_i = pc; is_in_delayslot_i = ds;
    data_addr_i = da; status_i = st; cause_i = ca; epc_i = epc;
    bus_busy_i = (busy_n > 0);
    ref_model(v, f, st, ca, pc, da, epc, det, code, bad, tgt);
    @(negedge clk);
    chk("stall_detect", {31'h0, stall_o}, {31'h0, det});
    if (!det) begin
      @(posedge clk); #1;
      mem_valid_i = 1'b0; bus_busy_i = 1'b0;
      @(negedge clk);
      chk("nodet_stall", {31'h0, stall_o}, 32'h0);
      chk_idle_outputs("nodet");
      return;
    end
    for (int i = 1; i < busy_n; i++) begin
      @(posedge clk); #1;
      scramble_inputs();
      bus_busy_i = 1'b1;
      @(negedge clk);
      chk("drain_stall", {31'h0, stall_o}, 32'h1);
      chk("drain_flush", {31'h0, flush_o}, 32'h0);
    end
    if (busy_n > 0) begin
      @(posedge clk); #1;
      scramble_inputs();
      bus_busy_i = 1'b0;
      @(negedge clk);
      chk("drain_last_stall", {31'h0, stall_o}, 32'h1);
    end
    @(posedge clk); #1;
    scramble_inputs();
    bus_busy_i = 1'($urandom);
    @(negedge clk);
    chk("commit_type", excepttype_o, code);
    chk("commit_addr", current_inst_addr_o, pc);
    chk("commit_ds", {31'h0, is_in_delayslot_o}, {31'h0, ds});
    chk("commit_bad", bad_addr_o, bad);
    chk("commit_flush", {31'h0, flush_o}, 32'h1);
    chk("commit_newpc", new_pc_o, tgt);
    chk("commit_stall", {31'h0, stall_o}, 32'h0);
    @(posedge clk); #1;
    mem_valid_i = 1'b0; bus_busy_i = 1'b0;
    @(negedge clk);
    chk("after_stall", {31'h0, stall_o}, 32'h0);
    chk_idle_outputs("after");
  endtask

  initial begin
    rst = 1'b0;
    mem_valid_i = 1'b0; pc_i = 0; is_in_delayslot_i = 1'b0; exc_flags_i = 0;
    data_addr_i = 0; status_i = 0; cause_i = 0; epc_i = 0; bus_busy_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset_stall", {31'h0, stall_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);

    // Syscall, bus idle.
    do_txn(1'b1, 9'h004, 32'h8000_0100, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
    // AdES with the bus busy for three cycles.
    do_txn(1'b1, 9'h080, 32'h8000_0200, 1'b0, 32'h8000_1003, 32'h0, 32'h0, 32'h0, 3);
    // All flags plus interrupt: interrupt wins.
    do_txn(1'b1, 9'h1FF, 32'h8000_0300, 1'b0, 32'h8000_4000, 32'h401, 32'h400, 32'h8000_2000, 0);
    // Same with EXL set: fetch AdEL wins.
    do_txn(1'b1, 9'h1FF, 32'h8000_0300, 1'b0, 32'h8000_4000, 32'h403, 32'h400, 32'h8000_2000, 0);
    // Interrupt masked by IE=0.
    do_txn(1'b1, 9'h000, 32'h8000_0304, 1'b0, 32'h0, 32'h400, 32'h400, 32'h0, 0);
    // ERET, with epc changing during DRAIN and commit.
    do_txn(1'b1, 9'h100, 32'h8000_0400, 1'b0, 32'h0, 32'h0, 32'h0, 32'h8000_2000, 0);
    do_txn(1'b1, 9'h100, 32'h8000_0404, 1'b0, 32'h0, 32'h0, 32'h0, 32'h8000_2010, 2);
    // RI in a delay slot.
    do_txn(1'b1, 9'h002, 32'h8000_0500, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 0);
    // Bubble with flags set: no detection.
    do_txn(1'b0, 9'h1FF, 32'h8000_0600, 1'b0, 32'h0, 32'h401, 32'h400, 32'h0, 0);

    // Reset in the middle of DRAIN aborts the commit.
    @(posedge clk); #1;
    mem_valid_i = 1'b1; exc_flags_i = 9'h004; pc_i = 32'h8000_0700; bus_busy_i = 1'b1;
    @(negedge clk);
    chk("rstdrain_stall0", {31'h0, stall_o}, 32'h1);
    @(posedge clk); #1;
    mem_valid_i = 1'b0; exc_flags_i = 9'h0;
    @(negedge clk);
    chk("rstdrain_stall1", {31'h0, stall_o}, 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; bus_busy_i = 1'b0;
    @(negedge clk);
    chk("rstdrain_stall2", {31'h0, stall_o}, 32'h0);
    chk_idle_outputs("rstdrain");
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstdrain_nocommit", {31'h0, flush_o}, 32'h0);

    // Random episodes.
    for (int n = 0; n < 60; n++) begin
      logic [8:0] f;
      logic [31:0] st, ca;
      f  = ($urandom_range(0, 3) == 0) ? 9'h0 : 9'($urandom);
      st = {16'h0, 8'($urandom), 6'h0, 1'($urandom), 1'($urandom)};
      ca = {16'h0, 8'($urandom), 8'h0};
      do_txn(($urandom_range(0, 5) != 0), f, $urandom, 1'($urandom), $urandom,
             st, ca, $urandom, $urandom_range(0, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/except_ctrl.md
# except_ctrl

Exception/interrupt commit controller at the MEM stage of the MIPS pipeline. It collects per-instruction exception flags and the pending-interrupt condition, and selects one exception by priority. It holds the pipeline until any outstanding data-bus transaction drains, then issues a one-cycle commit pulse. That pulse drives the CP0 exception inputs (`excepttype`, `current_inst_addr`, `is_in_delayslot`, `bad_addr`) together with the pipeline flush and the redirect PC.

## Interface
Parameters:
- `EXC_VECTOR`, default 32'hBFC00380: redirect PC for every exception other than ERET.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `mem_valid_i` in 1: the MEM-stage instruction is valid (not a bubble).
- `pc_i` in 32: PC of the MEM-stage instruction.
- `is_in_delayslot_i` in 1: the MEM-stage instruction is in a branch delay slot.
- `exc_flags_i` in 9: exception flags. [0] fetch AdEL, [1] RI, [2] syscall, [3] break, [4] overflow, [5] trap, [6] data AdEL, [7] AdES, [8] ERET.
- `data_addr_i` in 32: effective address of the load/store.
- `status_i`, `cause_i`, `epc_i` in 32 each: current CP0 values, already forwarded.
- `bus_busy_i` in 1: a data-bus transaction is outstanding.
- `excepttype_o` out 32: exception code to CP0. Zero when no commit.
- `current_inst_addr_o` out 32: PC of the excepting instruction, to CP0.
- `is_in_delayslot_o` out 1: delay-slot flag, to CP0.
- `bad_addr_o` out 32: faulting address, to CP0.
- `flush_o` out 1: flush all pipeline stages.
- `new_pc_o` out 32: redirect PC. Valid while `flush_o` is high.
- `stall_o` out 1: freeze IF..MEM.

## Operation
- Interrupt pending (`int_pend`) = `status_i[0]` & ~`status_i[1]` & |(`cause_i[15:8]` & `status_i[15:8]`).
- An exception is detected when `mem_valid_i` & (`int_pend` | |`exc_flags_i`). Detection is evaluated only in IDLE.
- Priority, highest first, with the resulting code:
  - interrupt 0x01
  - fetch AdEL 0x04
  - RI 0x0a
  - syscall 0x08
  - break 0x09
  - overflow 0x0c
  - trap 0x0d
  - data AdEL 0x04
  - AdES 0x05
  - ERET 0x0e
- Only the winning exception is committed. Lower-priority flags are discarded.
- Capture at detection, into internal registers:
  - code
  - `pc_i`
  - `is_in_delayslot_i`
  - bad address: `pc_i` for fetch AdEL, `data_addr_i` for data AdEL/AdES, 0 otherwise
  - target PC: `epc_i` for ERET, `EXC_VECTOR` otherwise
- FSM states: IDLE, DRAIN, COMMIT.
  - IDLE -> COMMIT: detection and ~`bus_busy_i`.
  - IDLE -> DRAIN: detection and `bus_busy_i`.
  - DRAIN -> COMMIT: `bus_busy_i`==0 in that cycle. Otherwise remain in DRAIN.
  - COMMIT -> IDLE: always.
- `stall_o` = (IDLE & detection) | DRAIN. It is combinational in the detection cycle.
- In COMMIT, the CP0 outputs, `flush_o`=1 and `new_pc_o` are driven from the captured registers, all registered. `stall_o`=0.
- Outside COMMIT: `excepttype_o`=0, `flush_o`=0. `current_inst_addr_o`, `is_in_delayslot_o`, `bad_addr_o` and `new_pc_o` are 0.
- Inputs are ignored in DRAIN and COMMIT. Captured values are not updated by later `status_i`/`epc_i` changes.

## Timing
- Reset (`rst`=0 at a clock edge): state IDLE, capture registers 0, all outputs 0. A reset during DRAIN or COMMIT aborts with no commit pulse on the following cycle.
- Latency, bus idle: detection in cycle N (`stall_o`=1) -> commit pulse in cycle N+1, exactly one cycle wide.
- Latency, bus busy: commit in the cycle after the first DRAIN cycle that sees `bus_busy_i`=0. `stall_o` stays high continuously until then.
- The cycle after COMMIT is IDLE. A new detection is permitted there; the flushed MEM stage normally presents `mem_valid_i`=0.
- Simultaneous interrupt and ERET: the interrupt wins (0x01) and `new_pc_o`=`EXC_VECTOR`.
- Interrupt with `status_i[1]`=1 (EXL) or `status_i[0]`=0: not taken.
- `mem_valid_i`=0 with flags set: no detection, no stall.

## Test plan
- Syscall, bus idle: `exc_flags_i`=9'h004, `pc_i`=32'h8000_0100, delay slot 0 at cycle N.
  - Cycle N: `stall_o`=1.
  - Cycle N+1: `excepttype_o`=0x08, `current_inst_addr_o`=0x80000100, `flush_o`=1, `new_pc_o`=0xBFC00380.
  - Cycle N+2: all outputs 0.
- AdES during a busy bus: flag [7] set, `data_addr_i`=0x80001003, `bus_busy_i`=1 for 3 cycles.
  - `stall_o`=1 for 4 cycles.
  - Commit then shows 0x05 with `bad_addr_o`=0x80001003.
- Priority: flags 9'h1FF, `status_i`=0x401 (IE=1, IM2=1), `cause_i`=0x400.
  - Commit `excepttype_o`=0x01.
  - Same stimulus with `status_i`=0x403 (EXL=1): 0x04, `bad_addr_o`=`pc_i`.
- ERET: flag [8] set, `epc_i`=0x8000_2000.
  - Commit 0x0e with `new_pc_o`=0x80002000.
  - A change of `epc_i` during the commit cycle does not alter the output.
- Delay slot: RI flag, `is_in_delayslot_i`=1 -> `is_in_delayslot_o`=1, `current_inst_addr_o`=`pc_i`.
- Reset mid-DRAIN: `rst`=0 for one edge while in DRAIN -> no commit pulse; `stall_o`=0 the next cycle.
